// File: rtl/adder_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_display_pkg
// Description : Shared constants for the adder result display. This holds the
//               hex glyph table ({g,f,e,d,c,b,a}, active-low), the blanked
//               anode/cathode patterns and the digit-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_display_pkg;

    // Physical digit positions on the display board.
    localparam int c_MAX_DIGITS = 8;

    localparam logic [7:0] c_ANODE_OFF   = 8'hFF;
    localparam logic [6:0] c_CATHODE_OFF = 7'h7F;

    // Hex glyphs 0..F, active-low segments {g,f,e,d,c,b,a}.
    localparam logic [6:0] c_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Hex digits needed to show DATA_WIDTH+1 bits ({cout,sum}).
    function automatic int num_digits(input int data_width);
        return (data_width + 4) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex-to-seven-segment glyph decoder.
//   i_nibble : 4-bit hex value
//   o_seg    : 7-bit segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import adder_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_GLYPH[i_nibble];

endmodule
`default_nettype wire

// File: rtl/adder_result_display.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_display
// Description : This block latches the {carry,sum} result of an N-bit adder.
//               It shows that result in hex on a multiplexed 8-digit, common-
//               anode seven-segment display. The decimal point of digit 0
//               marks an overflow (carry-out set).
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   res_valid    : single-cycle strobe qualifying res_sum/res_cout
//   res_sum      : adder sum, DATA_WIDTH bits
//   res_cout     : adder carry-out
//   res_latched  : captured {cout,sum}
//   seg_cathode  : segments {g..a}, active-low
//   seg_dp       : decimal point, active-low
//   seg_anode    : digit enables, active-low, bit 0 = rightmost
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_display
    import adder_display_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_sum,
    input  logic                  res_cout,
    output logic [DATA_WIDTH:0]   res_latched,
    output logic [6:0]            seg_cathode,
    output logic                  seg_dp,
    output logic [7:0]            seg_anode
);

    localparam int NUM_DIGITS = num_digits(DATA_WIDTH);
    localparam int c_CNT_W    = $clog2(REFRESH_DIV);
    localparam int c_EXT_W    = 4 * c_MAX_DIGITS;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [c_CNT_W-1:0]  r_cnt_q,     w_cnt_d;
    logic [2:0]          r_idx_q,     w_idx_d;
    logic [DATA_WIDTH:0] r_lat_q,     w_lat_d;
    logic [7:0]          r_anode_q,   w_anode_d;
    logic [6:0]          r_cathode_q, w_cathode_d;
    logic                r_dp_q,      w_dp_d;

    logic                w_tick;
    logic [c_EXT_W-1:0]  w_ext;
    logic [3:0]          w_nibble;

    always_comb begin
        w_tick  = (r_cnt_q == c_CNT_LAST);
        w_cnt_d = w_tick ? '0 : r_cnt_q + 1'b1;

        w_idx_d = r_idx_q;
        if (w_tick) begin
            w_idx_d = (r_idx_q == c_IDX_LAST) ? 3'd0 : r_idx_q + 3'd1;
        end

        w_lat_d = res_valid ? {res_cout, res_sum} : r_lat_q;

        // Display terms are derived from the current index/latched value and
        // registered, so a change appears one clock later. The index never
        // reaches NUM_DIGITS, which keeps the unused anodes dark.
        w_ext     = c_EXT_W'(r_lat_q);
        w_nibble  = w_ext[{r_idx_q, 2'b00} +: 4];
        w_anode_d = ~(8'b0000_0001 << r_idx_q);
        w_dp_d    = ~((r_idx_q == 3'd0) & r_lat_q[DATA_WIDTH]);
    end

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_cathode_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q     <= '0;
            r_idx_q     <= 3'd0;
            r_lat_q     <= '0;
            r_anode_q   <= c_ANODE_OFF;
            r_cathode_q <= c_CATHODE_OFF;
            r_dp_q      <= 1'b1;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_idx_q     <= w_idx_d;
            r_lat_q     <= w_lat_d;
            r_anode_q   <= w_anode_d;
            r_cathode_q <= w_cathode_d;
            r_dp_q      <= w_dp_d;
        end
    end

    assign res_latched = r_lat_q;
    assign seg_cathode = r_cathode_q;
    assign seg_dp      = r_dp_q;
    assign seg_anode   = r_anode_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_display
// Description : Self-checking bench for adder_result_display (DATA_WIDTH=8,
//               REFRESH_DIV=4). The reference counts clock edges since reset.
//               It derives the displayed digit as ((k-1)/REFRESH_DIV) mod
//               NUM_DIGITS and shows the {cout,sum} value held before the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_display;

    localparam int DW = 8;
    localparam int RD = 4;
    localparam int ND = (DW + 4) / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_cout = 1'b0;
    logic [DW-1:0] res_sum = '0;
    logic [DW:0]   res_latched;
    logic [6:0]    seg_cathode;
    logic          seg_dp;
    logic [7:0]    seg_anode;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference state: value held in the latch and edges since reset.
    logic [DW:0] m_lat = '0;
    int          m_k   = 0;

    adder_result_display #(.DATA_WIDTH(DW), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst         (rst),
        .res_valid   (res_valid),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .res_latched (res_latched),
        .seg_cathode (seg_cathode),
        .seg_dp      (seg_dp),
        .seg_anode   (seg_anode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the reference at the edge, then check.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] s, input logic c);
        logic [DW:0]  prev;
        logic [31:0]  wide;
        int           idx;
        logic [7:0]   e_an;
        logic [6:0]   e_ca;
        logic         e_dp;
        @(negedge clk);
        rst = r; res_valid = v; res_sum = s; res_cout = c;
        @(posedge clk);
        prev = m_lat;
        if (r) begin
            m_lat = '0;
            m_k   = 0;
        end else begin
            if (v) m_lat = {c, s};
            m_k++;
        end
        #1;
        if (r) begin
            e_an = 8'hFF; e_ca = 7'h7F; e_dp = 1'b1;
        end else begin
            idx  = ((m_k - 1) / RD) % ND;
            e_an = ~(8'h01 << idx);
            wide = 32'(prev) >> (4 * idx);
            e_ca = glyph[wide[3:0]];
            e_dp = !(idx == 0 && prev[DW]);
        end
        chk("latched", 32'(res_latched), 32'(m_lat));
        chk("anode",   32'(seg_anode),   32'(e_an));
        chk("cathode", 32'(seg_cathode), 32'(e_ca));
        chk("dp",      32'(seg_dp),      32'(e_dp));
        if (!r) begin
            chk("one_anode",   32'($countones(~seg_anode)), 32'd1);
            chk("unused_anode", 32'(seg_anode[7:3]), 32'h1F);
        end
    endtask

    initial begin
        // Reset held for three cycles, then released.
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_reset_anode",   32'(seg_anode),   32'hFE);
        chk("post_reset_cathode", 32'(seg_cathode), 32'h40);

        // Capture 0x13 without carry and scan all three digits twice.
        step(1'b0, 1'b1, 8'h13, 1'b0);
        chk("cap_013", 32'(res_latched), 32'h013);
        repeat (24) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Overflow result 0x101: dp lit on digit 0 only.
        step(1'b0, 1'b1, 8'h01, 1'b1);
        chk("cap_101", 32'(res_latched), 32'h101);
        repeat (24) step(1'b0, 1'b0, 8'h00, 1'b0);

        // res_valid on the same edge as a refresh tick.
        for (int i = 0; i < RD && ((m_k + 1) % RD) != 0; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        repeat (RD * ND) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset wins over res_valid, including mid-scan.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("rst_over_valid", 32'(res_latched), 32'h000);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Glyph sweep over every hex value on digit 0.
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b1, 8'(s), 1'b0);
            repeat (RD * ND) step(1'b0, 1'b0, 8'h00, 1'b0);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
